// File: rtl/serial_pattern_pkg.sv
// rtl/serial_pattern_pkg.sv - shared FSM type and default sizing for the serial pattern transmitter
//
// Purpose: FSM state enum and default parameter values used by
//          serial_pattern_tx and serial_pattern_shreg.
// Ports:   none (package).
package serial_pattern_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_GAP_CYCLES = 2;
  localparam int GAP_CNT_W      = 4;

endpackage

// File: rtl/serial_pattern_shreg.sv
// rtl/serial_pattern_shreg.sv - load/shift register with bit down-counter
//
// Purpose: holds the frame left-aligned so the bit currently on the line is
//          always the MSB; counts remaining bits down to zero.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   load              - capture load_pattern/load_len (overrides shift)
//   shift             - advance one bit toward the MSB
//   load_pattern      - raw pattern, bit load_len-1 is sent first
//   load_len          - bit count; 0 or above WIDTH means WIDTH
//   bit_out           - registered current serial bit
//   last_bit          - high while the final bit of the frame is on bit_out
module serial_pattern_shreg
  import serial_pattern_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_pattern,
  input  logic [LW-1:0]    load_len,
  output logic             bit_out,
  output logic             last_bit
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_cnt;
  logic [LW-1:0]    w_len;

  always_comb begin
    w_len = load_len;
    if (load_len == '0 || load_len > LW'(WIDTH)) begin
      w_len = LW'(WIDTH);
    end
  end

  // Left-aligning drops pattern bits above len-1 and fills zeros below, so
  // shifting past the final bit leaves the register (and the line) at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shreg <= '0;
      r_cnt   <= '0;
    end else if (load) begin
      r_shreg <= load_pattern << (LW'(WIDTH) - w_len);
      r_cnt   <= CW'(w_len - 1'b1);
    end else if (shift) begin
      r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign bit_out  = r_shreg[WIDTH-1];
  assign last_bit = (r_cnt == '0);

endmodule

// File: rtl/serial_pattern_tx.sv
// rtl/serial_pattern_tx.sv - MSB-first serial pattern transmitter with idle gap
//
// Purpose: sends len bits of pattern (bit len-1 first), then GAP_CYCLES low
//          cycles, then pulses done. Optional repeat mode is enabled by
//          defining SERIAL_PATTERN_TX_REPEAT_EN.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   start       - frame request, sampled only in IDLE
//   pattern     - bits to send
//   len         - bit count; 0 or above WIDTH means WIDTH
//   rpt         - (repeat build only) repeat the frame until stopped
//   stop        - (repeat build only) finish after the current gap
//   out         - serial bit stream
//   busy        - high during SHIFT and GAP
//   done        - one-cycle completion pulse
module serial_pattern_tx
  import serial_pattern_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [WIDTH-1:0]       pattern,
  input  logic [$clog2(WIDTH):0] len,
`ifdef SERIAL_PATTERN_TX_REPEAT_EN
  // "repeat" is a reserved word, hence rpt.
  input  logic                   rpt,
  input  logic                   stop,
`endif
  output logic                   out,
  output logic                   busy,
  output logic                   done
);

  localparam int LW = $clog2(WIDTH) + 1;
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'(GAP_CYCLES - 1);

  state_t                 r_state;
  logic                   r_busy;
  logic                   r_done;
  logic [GAP_CNT_W-1:0]   r_gap_cnt;

  logic                   w_load;
  logic                   w_shift;
  logic                   w_last_bit;
  logic                   w_gap_end;
  logic                   w_again;
  logic [WIDTH-1:0]       w_load_pattern;
  logic [LW-1:0]          w_load_len;

`ifdef SERIAL_PATTERN_TX_REPEAT_EN
  logic                   r_rpt;
  logic                   r_stop_seen;
  logic [WIDTH-1:0]       r_pattern;
  logic [LW-1:0]          r_len;

  // The captured copy feeds reloads; stop is latched so a short pulse
  // anywhere in the frame still ends it at the next gap boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rpt       <= 1'b0;
      r_stop_seen <= 1'b0;
      r_pattern   <= '0;
      r_len       <= '0;
    end else if (r_state == IDLE) begin
      if (start) begin
        r_rpt       <= rpt;
        r_stop_seen <= 1'b0;
        r_pattern   <= pattern;
        r_len       <= len;
      end
    end else if (stop) begin
      r_stop_seen <= 1'b1;
    end
  end
`endif

  always_comb begin
    w_gap_end = (r_state == GAP) && (r_gap_cnt == '0);
`ifdef SERIAL_PATTERN_TX_REPEAT_EN
    w_again        = w_gap_end && r_rpt && !r_stop_seen && !stop;
    w_load_pattern = (r_state == IDLE) ? pattern : r_pattern;
    w_load_len     = (r_state == IDLE) ? len : r_len;
`else
    w_again        = 1'b0;
    w_load_pattern = pattern;
    w_load_len     = len;
`endif
    w_load  = ((r_state == IDLE) && start) || w_again;
    w_shift = (r_state == SHIFT);
  end

  serial_pattern_shreg #(
    .WIDTH (WIDTH),
    .LW    (LW)
  ) u_shreg (
    .clk          (clk),
    .reset        (reset),
    .load         (w_load),
    .shift        (w_shift),
    .load_pattern (w_load_pattern),
    .load_len     (w_load_len),
    .bit_out      (out),
    .last_bit     (w_last_bit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_gap_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= SHIFT;
            r_busy  <= 1'b1;
          end
        end
        SHIFT: begin
          if (w_last_bit) begin
            r_state   <= GAP;
            r_gap_cnt <= GAP_LOAD;
          end
        end
        GAP: begin
          if (w_again) begin
            r_state <= SHIFT;
          end else if (w_gap_end) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;

endmodule
